// File: rtl/hash_row_coalescer.sv
`default_nettype none
// ============================================================================
// Module   : hash_row_coalescer
// Purpose  : Merges successive sparse hash-issue beats (one history row per
//            lane) into a single dense beat. A beat is merged lane by lane with
//            a bitwise OR while its row_valid lanes do not collide with lanes
//            already buffered. The merged beat is flushed on a beat count,
//            a full row mask, an end-of-block delimiter, a lane conflict or an
//            idle timeout, and passes through a one-entry output register.
// Ports    :
//   clk, rst            - clock, synchronous active-high reset
//   cfg_max_beats       - beats merged before a forced flush (0 acts as 1)
//   cfg_timeout         - idle ACCUM cycles before a forced flush (0 = off)
//   in_valid/in_ready   - input beat handshake
//   in_head_addr        - head address of the beat
//   in_row_valid        - per-lane row present
//   in_hist_valid/addr  - per-slot history valid flag and address
//   in_meta_len/ext     - per-slot match length and can-extend flag
//   in_data, in_delim   - beat data bytes and end-of-block marker
//   out_*               - merged beat, same layout as in_*
//   out_valid/out_ready - output handshake
//   out_cause           - flush cause: 0 count/full, 1 delim, 2 conflict,
//                         3 timeout
// Revision : 1.0 - initial release
// ============================================================================
module hash_row_coalescer #(
  parameter int LANES      = 8,
  parameter int LANES_LOG2 = 3,
  parameter int ROW_SIZE   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int META_W     = 5,
  parameter int TMO_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [LANES_LOG2:0]                  cfg_max_beats,
  input  logic [TMO_W-1:0]                     cfg_timeout,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ADDR_WIDTH-1:0]                in_head_addr,
  input  logic [LANES-1:0]                     in_row_valid,
  input  logic [LANES*ROW_SIZE-1:0]            in_hist_valid,
  input  logic [LANES*ROW_SIZE*ADDR_WIDTH-1:0] in_hist_addr,
  input  logic [LANES*ROW_SIZE*META_W-1:0]     in_meta_len,
  input  logic [LANES*ROW_SIZE-1:0]            in_meta_ext,
  input  logic [LANES*8-1:0]                   in_data,
  input  logic                                 in_delim,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ADDR_WIDTH-1:0]                out_head_addr,
  output logic [LANES-1:0]                     out_row_valid,
  output logic [LANES*ROW_SIZE-1:0]            out_hist_valid,
  output logic [LANES*ROW_SIZE*ADDR_WIDTH-1:0] out_hist_addr,
  output logic [LANES*ROW_SIZE*META_W-1:0]     out_meta_len,
  output logic [LANES*ROW_SIZE-1:0]            out_meta_ext,
  output logic [LANES*8-1:0]                   out_data,
  output logic                                 out_delim,
  output logic [1:0]                           out_cause
);

  localparam int c_SLOTS = LANES * ROW_SIZE;
  localparam int c_CNT_W = LANES_LOG2 + 1;

  localparam logic [1:0] c_CAUSE_COUNT    = 2'd0;
  localparam logic [1:0] c_CAUSE_DELIM    = 2'd1;
  localparam logic [1:0] c_CAUSE_CONFLICT = 2'd2;
  localparam logic [1:0] c_CAUSE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Merge buffer. All lane fields stay zero while nothing is buffered so the
  // OR-merge of the first beat needs no special case.
  logic [c_CNT_W-1:0]              r_count;
  logic [TMO_W-1:0]                r_tmo;
  logic [LANES-1:0]                r_buf_row;
  logic [c_SLOTS-1:0]              r_buf_hv;
  logic [c_SLOTS*ADDR_WIDTH-1:0]   r_buf_ha;
  logic [c_SLOTS*META_W-1:0]       r_buf_ml;
  logic [c_SLOTS-1:0]              r_buf_me;
  logic [ADDR_WIDTH-1:0]           r_buf_head;
  logic [LANES*8-1:0]              r_buf_data;
  logic                            r_buf_delim;
  logic [1:0]                      r_buf_cause;

  // Merge datapath
  logic [c_SLOTS-1:0]              w_slot_en;
  logic [LANES-1:0]                w_merge_row;
  logic [c_SLOTS-1:0]              w_merge_hv;
  logic [c_SLOTS*ADDR_WIDTH-1:0]   w_merge_ha;
  logic [c_SLOTS*META_W-1:0]       w_merge_ml;
  logic [c_SLOTS-1:0]              w_merge_me;

  // Flush source: the freshly merged beat on an accepting cycle, otherwise
  // whatever is already in the buffer.
  logic [LANES-1:0]                w_src_row;
  logic [c_SLOTS-1:0]              w_src_hv;
  logic [c_SLOTS*ADDR_WIDTH-1:0]   w_src_ha;
  logic [c_SLOTS*META_W-1:0]       w_src_ml;
  logic [c_SLOTS-1:0]              w_src_me;
  logic [ADDR_WIDTH-1:0]           w_src_head;
  logic [LANES*8-1:0]              w_src_data;
  logic                            w_src_delim;
  logic [LANES-1:0]                w_src_row_or;

  // Control
  logic                            w_can_load;
  logic                            w_conflict;
  logic [c_CNT_W-1:0]              w_max_eff;
  logic [c_CNT_W:0]                w_cnt_inc;
  logic                            w_cnt_hit;
  logic                            w_full;
  logic                            w_acc_flush;
  logic [1:0]                      w_acc_cause;
  logic [TMO_W:0]                  w_tmo_inc;
  logic                            w_tmo_hit;
  logic                            w_accept;
  logic                            w_flush;
  logic                            w_load;
  logic [1:0]                      w_cause;

  // --------------------------------------------------------------------------
  // Lane-gated OR merge
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane_en
    assign w_slot_en[g*ROW_SIZE +: ROW_SIZE] = {ROW_SIZE{in_row_valid[g]}};
  end

  for (genvar s = 0; s < c_SLOTS; s++) begin : g_slot_merge
    assign w_merge_ha[s*ADDR_WIDTH +: ADDR_WIDTH] =
        r_buf_ha[s*ADDR_WIDTH +: ADDR_WIDTH] |
        (in_hist_addr[s*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_slot_en[s]}});
    assign w_merge_ml[s*META_W +: META_W] =
        r_buf_ml[s*META_W +: META_W] |
        (in_meta_len[s*META_W +: META_W] & {META_W{w_slot_en[s]}});
  end

  assign w_merge_row = r_buf_row | in_row_valid;
  assign w_merge_hv  = r_buf_hv  | (in_hist_valid & w_slot_en);
  assign w_merge_me  = r_buf_me  | (in_meta_ext   & w_slot_en);

  assign w_src_row   = w_accept ? w_merge_row  : r_buf_row;
  assign w_src_hv    = w_accept ? w_merge_hv   : r_buf_hv;
  assign w_src_ha    = w_accept ? w_merge_ha   : r_buf_ha;
  assign w_src_ml    = w_accept ? w_merge_ml   : r_buf_ml;
  assign w_src_me    = w_accept ? w_merge_me   : r_buf_me;
  assign w_src_head  = w_accept ? in_head_addr : r_buf_head;
  assign w_src_data  = w_accept ? in_data      : r_buf_data;
  assign w_src_delim = w_accept ? in_delim     : r_buf_delim;

  // Reported row_valid reflects real history content: a lane that was marked
  // present but carried no valid slots is reported absent.
  for (genvar g = 0; g < LANES; g++) begin : g_row_or
    assign w_src_row_or[g] = |w_src_hv[g*ROW_SIZE +: ROW_SIZE];
  end

  // --------------------------------------------------------------------------
  // Flush conditions
  // --------------------------------------------------------------------------
  assign w_can_load  = !out_valid || out_ready;
  assign w_conflict  = (r_state == S_ACCUM) && in_valid &&
                       ((in_row_valid & r_buf_row) != '0);

  assign w_max_eff   = (cfg_max_beats == '0) ? c_CNT_W'(1) : cfg_max_beats;
  assign w_cnt_inc   = {1'b0, r_count} + 1'b1;
  assign w_cnt_hit   = w_cnt_inc >= {1'b0, w_max_eff};
  assign w_full      = &w_merge_row;
  assign w_acc_flush = w_cnt_hit || w_full || in_delim;
  assign w_acc_cause = in_delim ? c_CAUSE_DELIM : c_CAUSE_COUNT;

  // Timeout fires on the idle cycle whose increment reaches cfg_timeout.
  assign w_tmo_inc   = {1'b0, r_tmo} + 1'b1;
  assign w_tmo_hit   = (cfg_timeout != '0) && (w_tmo_inc >= {1'b0, cfg_timeout});

  assign w_load      = w_flush && w_can_load;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    w_accept   = 1'b0;
    w_flush    = 1'b0;
    w_cause    = c_CAUSE_COUNT;

    case (r_state)
      S_EMPTY: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_acc_flush) begin
            w_flush = 1'b1;
            w_cause = w_acc_cause;
          end
        end
      end
      S_ACCUM: begin
        if (w_conflict) begin
          // Push the buffer out first; the colliding beat is taken later.
          w_flush = 1'b1;
          w_cause = c_CAUSE_CONFLICT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_accept = 1'b1;
            if (w_acc_flush) begin
              w_flush = 1'b1;
              w_cause = w_acc_cause;
            end
          end else if (w_tmo_hit) begin
            w_flush = 1'b1;
            w_cause = c_CAUSE_TIMEOUT;
          end
        end
      end
      S_FLUSH: begin
        w_flush = 1'b1;
        w_cause = r_buf_cause;
      end
      default: begin
        w_state_nx = S_EMPTY;
      end
    endcase

    if (rst) begin
      in_ready = 1'b0;
      w_accept = 1'b0;
      w_flush  = 1'b0;
    end

    if (w_flush) begin
      w_state_nx = w_can_load ? S_EMPTY : S_FLUSH;
    end else if (w_accept) begin
      w_state_nx = S_ACCUM;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer, counters and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count        <= '0;
      r_tmo          <= '0;
      r_buf_row      <= '0;
      r_buf_hv       <= '0;
      r_buf_ha       <= '0;
      r_buf_ml       <= '0;
      r_buf_me       <= '0;
      r_buf_head     <= '0;
      r_buf_data     <= '0;
      r_buf_delim    <= 1'b0;
      r_buf_cause    <= c_CAUSE_COUNT;
      out_valid      <= 1'b0;
      out_head_addr  <= '0;
      out_row_valid  <= '0;
      out_hist_valid <= '0;
      out_hist_addr  <= '0;
      out_meta_len   <= '0;
      out_meta_ext   <= '0;
      out_data       <= '0;
      out_delim      <= 1'b0;
      out_cause      <= c_CAUSE_COUNT;
    end else begin
      // Beat counter: saturating, cleared by any flush.
      if (w_flush) begin
        r_count <= '0;
      end else if (w_accept && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end

      // Idle counter: only runs while holding an unflushed buffer.
      if (w_flush || w_accept) begin
        r_tmo <= '0;
      end else if ((r_state == S_ACCUM) && (r_tmo != '1)) begin
        r_tmo <= r_tmo + 1'b1;
      end

      // Buffer: emptied when its content reaches the output register,
      // otherwise it captures the merge (or parks a blocked flush).
      if (w_load) begin
        r_buf_row   <= '0;
        r_buf_hv    <= '0;
        r_buf_ha    <= '0;
        r_buf_ml    <= '0;
        r_buf_me    <= '0;
        r_buf_head  <= '0;
        r_buf_data  <= '0;
        r_buf_delim <= 1'b0;
        r_buf_cause <= c_CAUSE_COUNT;
      end else if (w_flush || w_accept) begin
        r_buf_row   <= w_src_row;
        r_buf_hv    <= w_src_hv;
        r_buf_ha    <= w_src_ha;
        r_buf_ml    <= w_src_ml;
        r_buf_me    <= w_src_me;
        r_buf_head  <= w_src_head;
        r_buf_data  <= w_src_data;
        r_buf_delim <= w_src_delim;
        r_buf_cause <= w_cause;
      end

      // One-entry forward register: holds while stalled downstream.
      if (w_can_load) begin
        out_valid <= w_load;
        if (w_load) begin
          out_head_addr  <= w_src_head;
          out_row_valid  <= w_src_row_or;
          out_hist_valid <= w_src_hv;
          out_hist_addr  <= w_src_ha;
          out_meta_len   <= w_src_ml;
          out_meta_ext   <= w_src_me;
          out_data       <= w_src_data;
          out_delim      <= w_src_delim;
          out_cause      <= w_cause;
        end
      end
    end
  end

endmodule
`default_nettype wire
